// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   Initiator side of the MEM-stage data-memory interface. Accepts one load
//   or store per request. Loads are extracted and extended from the addressed
//   byte or halfword lane. Sub-word stores are performed as a read-modify-write
//   of the containing word. Requests that are misaligned or have an illegal
//   size are answered with an error and never touch memory.
// Ports
//   lsu_clk, lsu_reset_n        clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata/pc  request fields, captured on accept
//   resp_valid/resp_ready       response handshake (response held until taken)
//   resp_rdata, resp_err        load result (0 for stores/errors), error flag
//   mem_addr/wdata/we, mem_rdata  word-wide memory port (combinational read)
module dm_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              lsu_clk,
    input  logic              lsu_reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;   // store data, later the merged word
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    // Size 11 is reserved; halfwords and words must be naturally aligned.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   is_illegal = 1'b0;
            2'b01:   is_illegal = lane[0];
            2'b10:   is_illegal = (lane != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    // Pick the addressed lane out of the word and zero- or sign-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extract = {{24{sext & b[7]}}, b};
            2'b01:   load_extract = {{16{sext & h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    // Overlay the low byte/half of the store data onto the read word at the lane.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = word;
        case (size)
            2'b00:   w[8*lane +: 8] = data[7:0];
            2'b01:   w[16*lane[1] +: 16] = data[15:0];
            default: w = data;
        endcase
        store_merge = w;
    endfunction

    // Next-state and datapath capture for the request FSM.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        pc_d     = pc_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    pc_d     = req_pc;
                    rdata_d  = 32'h0000_0000;
                    err_d    = 1'b0;
                    if (is_illegal(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (we_q) begin
                    wdata_d = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_extract(mem_rdata, size_q, addr_q[1:0], signed_q);
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge lsu_clk or negedge lsu_reset_n) begin
        if (!lsu_reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= {ADDR_W{1'b0}};
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            pc_q     <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            pc_q     <= pc_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs are decoded from registered state only, so reset clears them at once.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign mem_we     = (state_q == ST_WR);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = wdata_q;

`ifndef SYNTHESIS
    // Store trace, one line per committed memory write.
    always_ff @(posedge lsu_clk) begin
        if (state_q == ST_WR) begin
            $display("@%h:*%h<=%h", pc_q, mem_addr, mem_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl
//   Directed bench for dm_access_ctrl with a small word memory model.
module tb_dm_access_ctrl;

    logic        lsu_clk;
    logic        lsu_reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          we_cnt;
    logic [31:0] we_addr;
    int          checks;
    int          failures;

    dm_access_ctrl #(.ADDR_W(32)) dut (
        .lsu_clk     (lsu_clk),
        .lsu_reset_n (lsu_reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_pc      (req_pc),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    initial lsu_clk = 1'b0;
    always #5 lsu_clk = ~lsu_clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge lsu_clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_cnt             <= we_cnt + 1;
            we_addr            <= mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after the accept edge; returns cycles from accept to resp_valid.
    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
        @(negedge lsu_clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge lsu_clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    // Present a request at a negedge, let it be accepted, collect and retire the response.
    task automatic send(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_pc = 32'h0000_1000 + a;
        req_valid = 1'b1;
        @(posedge lsu_clk);
        wait_resp(lat, rd, er);
        resp_ready = 1'b1;
        @(negedge lsu_clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          w0;
        logic [31:0] rd, rd0;
        logic        er;
        checks = 0; failures = 0; we_cnt = 0; we_addr = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        lsu_reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        repeat (2) @(negedge lsu_clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        lsu_reset_n = 1'b1;
        @(negedge lsu_clk);

        // 1. loads with extension
        mem[32] = 32'h1234_8765;
        mem[4]  = 32'hAABB_CCDD;
        send(1'b0, 2'b01, 1'b1, 32'h80, 32'h0, lat, rd, er);
        check("lh_80", rd, 32'hFFFF_8765);
        check("lh_lat", lat, 32'd2);
        send(1'b0, 2'b01, 1'b0, 32'h82, 32'h0, lat, rd, er);
        check("lhu_82", rd, 32'h0000_1234);
        send(1'b0, 2'b00, 1'b1, 32'h81, 32'h0, lat, rd, er);
        check("lb_81", rd, 32'hFFFF_FF87);
        send(1'b0, 2'b00, 1'b0, 32'h83, 32'h0, lat, rd, er);
        check("lbu_83", rd, 32'h0000_0012);
        send(1'b0, 2'b00, 1'b1, 32'h83, 32'h0, lat, rd, er);
        check("lb_83_pos", rd, 32'h0000_0012);

        // 2. sub-word stores via read-modify-write
        w0 = we_cnt;
        send(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FF11, lat, rd, er);
        check("sb_we_pulses", we_cnt - w0, 32'd1);
        check("sb_mem", mem[4], 32'hAA11_CCDD);
        check("sb_lat", lat, 32'd3);
        check("sb_rdata", rd, 32'h0);
        send(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_5566, lat, rd, er);
        check("sh_mem", mem[4], 32'h5566_CCDD);

        // 3. word store then load back
        w0 = we_cnt;
        send(1'b1, 2'b10, 1'b0, 32'h04, 32'hDEAD_BEEF, lat, rd, er);
        check("sw_we_pulses", we_cnt - w0, 32'd1);
        check("sw_we_addr", we_addr, 32'h04);
        check("sw_lat", lat, 32'd2);
        check("sw_err", {31'b0, er}, 32'd0);
        send(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, lat, rd, er);
        check("lw_04", rd, 32'hDEAD_BEEF);

        // 4. illegal requests
        w0 = we_cnt;
        send(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, rd, er);
        check("lw06_err", {31'b0, er}, 32'd1);
        check("lw06_rdata", rd, 32'h0);
        check("lw06_lat", lat, 32'd1);
        send(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234_5678, lat, rd, er);
        check("sh03_err", {31'b0, er}, 32'd1);
        check("sh03_lat", lat, 32'd1);
        send(1'b1, 2'b11, 1'b0, 32'h08, 32'h1234_5678, lat, rd, er);
        check("sz11_err", {31'b0, er}, 32'd1);
        check("sz11_rdata", rd, 32'h0);
        check("err_no_we", we_cnt - w0, 32'd0);
        check("err_mem_04", mem[1], 32'hDEAD_BEEF);

        // 5. response held under back-pressure with a pending second request
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h80;
        req_valid = 1'b1;
        @(posedge lsu_clk);
        wait_resp(lat, rd0, er);
        check("bp_first", rd0, 32'h1234_8765);
        req_addr = 32'h04; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge lsu_clk);
            check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'h1234_8765);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge lsu_clk);
        @(negedge lsu_clk);
        resp_ready = 1'b0;
        check("bp_idle_ready", {31'b0, req_ready}, 32'd1);
        check("bp_idle_resp", {31'b0, resp_valid}, 32'd0);
        @(posedge lsu_clk);
        wait_resp(lat, rd, er);
        check("bp_second", rd, 32'hDEAD_BEEF);
        check("bp_second_lat", lat, 32'd2);
        resp_ready = 1'b1;
        @(negedge lsu_clk);
        resp_ready = 1'b0;

        // 6. reset during the read phase of a byte store
        w0 = we_cnt;
        req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h99;
        req_valid = 1'b1;
        @(posedge lsu_clk);
        #1;
        req_valid = 1'b0;
        lsu_reset_n = 1'b0;
        #1;
        check("rrd_req_ready", {31'b0, req_ready}, 32'd1);
        check("rrd_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rrd_mem_we", {31'b0, mem_we}, 32'd0);
        repeat (2) @(negedge lsu_clk);
        lsu_reset_n = 1'b1;
        repeat (3) @(negedge lsu_clk);
        check("rrd_no_we", we_cnt - w0, 32'd0);
        check("rrd_mem", mem[4], 32'h5566_CCDD);
        check("rrd_idle", {31'b0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
